// File: rtl/reset_sequencer.sv
// Staged reset controller: releases MIG, then GT, then user-logic resets in order,
// with per-stage hold times, wait timeouts, bounded retries and run-time loss recovery.
module reset_sequencer #(
  parameter int MIG_RST_LEN  = 16,
  parameter int GT_RST_LEN   = 16,
  parameter int USER_RST_LEN = 16,
  parameter int TIMEOUT      = 1000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                               clk_sys,
  input  logic                               rst_sys,
  input  logic                               mig_calib_done,
  input  logic                               gt_ready,
  output logic                               rst_mig,
  output logic                               rst_gt,
  output logic                               rst_user,
  output logic                               seq_ready,
  output logic                               seq_error,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
  output logic [7:0]                         drop_cnt,
  output logic [2:0]                         seq_state
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HOLD_MAX = (MIG_RST_LEN > GT_RST_LEN)
                          ? ((MIG_RST_LEN > USER_RST_LEN) ? MIG_RST_LEN : USER_RST_LEN)
                          : ((GT_RST_LEN > USER_RST_LEN) ? GT_RST_LEN : USER_RST_LEN);
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_MIG_RST  = 3'd1,
    S_MIG_WAIT = 3'd2,
    S_GT_RST   = 3'd3,
    S_GT_WAIT  = 3'd4,
    S_USER_RST = 3'd5,
    S_RUN      = 3'd6,
    S_FAIL     = 3'd7
  } state_t;

  state_t        state_reg, state_next;
  state_t        fail_target;
  logic          fail_attempt;
  logic [HW-1:0] hold_reg, hold_next;
  logic [TW-1:0] wait_reg, wait_next;
  logic [RW-1:0] retry_next;
  logic [7:0]    drop_next;
  logic [1:0]    mig_sync_reg, gt_sync_reg;
  logic          mig_ok, gt_ok;
  logic          rst_mig_next, rst_gt_next, rst_user_next, seq_ready_next, seq_error_next;
  logic          wait_expired;

  assign mig_ok       = mig_sync_reg[1];
  assign gt_ok        = gt_sync_reg[1];
  assign seq_state    = state_reg;
  assign wait_expired = (wait_reg == TW'(TIMEOUT - 1));

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    wait_next    = wait_reg;
    retry_next   = retry_cnt;
    drop_next    = drop_cnt;
    fail_attempt = 1'b0;
    fail_target  = S_MIG_RST;

    case (state_reg)
      S_RESET: state_next = S_MIG_RST;
      S_MIG_RST: begin
        if (hold_reg == '0) state_next = S_MIG_WAIT;
        else                hold_next  = hold_reg - HW'(1);
      end
      S_MIG_WAIT: begin
        // Status beats a timeout that lands on the same edge.
        if (mig_ok)            state_next = S_GT_RST;
        else if (wait_expired) fail_attempt = 1'b1;
        else                   wait_next = wait_reg + TW'(1);
      end
      S_GT_RST: begin
        if (hold_reg == '0) state_next = S_GT_WAIT;
        else                hold_next  = hold_reg - HW'(1);
      end
      S_GT_WAIT: begin
        if (!mig_ok) begin
          fail_attempt = 1'b1;
        end else if (gt_ok) begin
          state_next = S_USER_RST;
        end else if (wait_expired) begin
          fail_attempt = 1'b1;
          fail_target  = S_GT_RST;
        end else begin
          wait_next = wait_reg + TW'(1);
        end
      end
      S_USER_RST: begin
        if (!mig_ok) begin
          fail_attempt = 1'b1;
        end else if (!gt_ok) begin
          fail_attempt = 1'b1;
          fail_target  = S_GT_RST;
        end else if (hold_reg == '0) begin
          state_next = S_RUN;
          retry_next = '0;
        end else begin
          hold_next = hold_reg - HW'(1);
        end
      end
      S_RUN: begin
        // Run-time drops restart the sequence without consuming a retry.
        if (!mig_ok || !gt_ok) begin
          state_next = !mig_ok ? S_MIG_RST : S_GT_RST;
          if (drop_cnt != 8'hFF) drop_next = drop_cnt + 8'd1;
        end
      end
      S_FAIL: state_next = S_FAIL;
      default: state_next = S_FAIL;
    endcase

    if (fail_attempt) begin
      if (retry_cnt < RW'(MAX_RETRY)) begin
        retry_next = retry_cnt + RW'(1);
        state_next = fail_target;
      end else begin
        state_next = S_FAIL;
      end
    end

    if (state_next != state_reg) begin
      wait_next = '0;
      case (state_next)
        S_MIG_RST:  hold_next = HW'(MIG_RST_LEN - 1);
        S_GT_RST:   hold_next = HW'(GT_RST_LEN - 1);
        S_USER_RST: hold_next = HW'(USER_RST_LEN - 1);
        default:    hold_next = '0;
      endcase
    end

    rst_mig_next   = state_next inside {S_RESET, S_MIG_RST, S_FAIL};
    rst_gt_next    = state_next inside {S_RESET, S_MIG_RST, S_MIG_WAIT, S_GT_RST, S_FAIL};
    rst_user_next  = (state_next != S_RUN);
    seq_ready_next = (state_next == S_RUN);
    seq_error_next = (state_next == S_FAIL);
  end

  // Each status synchronizer is held clear while its block is in reset, so a level
  // left over from before the reset is never mistaken for a fresh completion.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_reg    <= S_RESET;
      hold_reg     <= '0;
      wait_reg     <= '0;
      retry_cnt    <= '0;
      drop_cnt     <= '0;
      rst_mig      <= 1'b1;
      rst_gt       <= 1'b1;
      rst_user     <= 1'b1;
      seq_ready    <= 1'b0;
      seq_error    <= 1'b0;
      mig_sync_reg <= '0;
      gt_sync_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      wait_reg     <= wait_next;
      retry_cnt    <= retry_next;
      drop_cnt     <= drop_next;
      rst_mig      <= rst_mig_next;
      rst_gt       <= rst_gt_next;
      rst_user     <= rst_user_next;
      seq_ready    <= seq_ready_next;
      seq_error    <= seq_error_next;
      mig_sync_reg <= rst_mig_next ? 2'b00 : {mig_sync_reg[0], mig_calib_done};
      gt_sync_reg  <= rst_gt_next  ? 2'b00 : {gt_sync_reg[0], gt_ready};
    end
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset controller in the `clk_sys` domain, directly downstream of the clock/reset generation stage. It takes the raw `rst_sys` and the asynchronous status flags from the MIG and the GT transceiver. It releases the MIG, GT and user-logic resets in a fixed order, with timeouts, bounded retries and run-time loss recovery. Its outputs drive the memory controller, the transceiver wrapper and the application logic.

## Interface
Parameters:
- `MIG_RST_LEN`, 16: cycles `rst_mig` is held per attempt (≥1)
- `GT_RST_LEN`, 16: cycles `rst_gt` is held per attempt (≥1)
- `USER_RST_LEN`, 16: cycles `rst_user` is held after GT ready (≥1)
- `TIMEOUT`, 1000000: max wait cycles for MIG calibration or GT ready (≥2)
- `MAX_RETRY`, 3: consecutive failed attempts tolerated before fail state

Ports:
- `clk_sys` in 1: system clock
- `rst_sys` in 1: synchronous, active-high reset; forces the reset state on the next edge
- `mig_calib_done` in 1: MIG calibration complete, asynchronous
- `gt_ready` in 1: GT reset done / link up, asynchronous
- `rst_mig` out 1: MIG reset, active-high
- `rst_gt` out 1: GT reset, active-high
- `rst_user` out 1: user logic reset, active-high
- `seq_ready` out 1: sequence complete, system running
- `seq_error` out 1: retries exhausted
- `retry_cnt` out $clog2(MAX_RETRY+1): consecutive failed attempts
- `drop_cnt` out 8: saturating count of status losses in RUN
- `seq_state` out 3: FSM state code (debug)

## Operation
- All outputs are registered.
- Reset values: `rst_mig`=`rst_gt`=`rst_user`=1, `seq_ready`=0, `seq_error`=0, `retry_cnt`=0, `drop_cnt`=0, `seq_state`=0.
- `mig_calib_done` and `gt_ready` each pass through a 2-flop synchronizer. The FSM uses only the synchronized copies (`mig_ok`, `gt_ok`).
- State codes: RESET=0, MIG_RST=1, MIG_WAIT=2, GT_RST=3, GT_WAIT=4, USER_RST=5, RUN=6, FAIL=7.
- Transitions:
  - RESET → MIG_RST on the first edge sampling `rst_sys`=0.
  - MIG_RST: `rst_mig`/`rst_gt`/`rst_user` high. Counts `MIG_RST_LEN` cycles, then → MIG_WAIT with `rst_mig`=0.
  - MIG_WAIT: `mig_ok` → GT_RST. Timeout → retry to MIG_RST.
  - GT_RST: `rst_gt` high for `GT_RST_LEN` cycles, then → GT_WAIT with `rst_gt`=0.
  - GT_WAIT: `gt_ok` → USER_RST. Timeout → retry to GT_RST. Loss of `mig_ok` → retry to MIG_RST (MIG takes precedence).
  - USER_RST: `rst_user` high for `USER_RST_LEN` cycles, then → RUN. Entering RUN sets `rst_user`=0 and `seq_ready`=1, and clears `retry_cnt`.
  - RUN: loss of `mig_ok` → MIG_RST. Loss of only `gt_ok` → GT_RST. Either loss increments `drop_cnt` once (saturates at 255) and does not touch `retry_cnt`. Both lost on the same edge → one MIG_RST restart, one `drop_cnt` increment.
  - USER_RST: loss of `mig_ok` or `gt_ok` counts as a failed attempt; MIG loss → MIG_RST, otherwise → GT_RST.
- Failed attempt rule:
  - If `retry_cnt` < `MAX_RETRY`: `retry_cnt`+1, then the restart target.
  - Otherwise: → FAIL with `seq_error`=1 and all resets high. FAIL holds until `rst_sys`.
- Resets re-assert as follows:
  - Restart to MIG_RST re-asserts all three resets on the transition edge.
  - Restart to GT_RST re-asserts `rst_gt` and `rst_user`; `rst_mig` stays 0.
  - `seq_ready` drops on any exit from RUN.
- `rst_sys` high in any state: next edge → RESET with all outputs at reset values, counters included. Synchronizers are also cleared.

## Timing
- E0 is the first edge sampling `rst_sys`=0; the FSM enters MIG_RST at E0.
- `rst_mig` falls at edge E(`MIG_RST_LEN`).
- Hold counters reload on every state entry. A reset held in state X is high for exactly `X_LEN` cycles.
- Status latency: an input first sampled high at edge Ek is acted on at edge Ek+2. The resulting output changes at Ek+2.
- Timeout:
  - Fires on the `TIMEOUT`-th edge after entering a WAIT state if the synchronized status is still low.
  - Status arriving on that same edge wins; no timeout is taken.
  - Timeout counter width is $clog2(`TIMEOUT`+1).
- Status loss in RUN (input sampled low at Ek) re-asserts the affected resets at Ek+2.
- `seq_state` is updated on the same edge as the state register.

## Test plan
Parameters for all scenarios: `MIG_RST_LEN`=4, `GT_RST_LEN`=3, `USER_RST_LEN`=2, `TIMEOUT`=20, `MAX_RETRY`=2.
- Nominal bring-up:
  - Stimulus: both status inputs already high; release `rst_sys` at E0.
  - Required: `rst_mig`↓E4; `rst_gt`↓E4+2+3=E9; `rst_user`↓ and `seq_ready`↑ at E9+2+2=E13; `retry_cnt`=0.
- MIG never calibrates:
  - Stimulus: `mig_calib_done` held 0.
  - Required: timeouts every 24 cycles; `retry_cnt` steps 1 → 2.
  - Required on the third timeout: `seq_state`=7, `seq_error`=1, all resets high.
  - Stays in FAIL until `rst_sys`.
- GT timeout then success:
  - Stimulus: `gt_ready` rises 30 cycles after `rst_gt`↓.
  - Required: one GT_RST restart with `rst_mig` staying 0; `retry_cnt`=1; RUN reached, which clears `retry_cnt` to 0.
- Run-time losses:
  - Stimulus: in RUN, pulse `gt_ready` low for 1 cycle.
  - Required: `rst_gt`/`rst_user`↑ 2 edges later, `drop_cnt`=1, `rst_mig` stays 0, RUN re-entered.
  - Stimulus: repeat with both inputs low on the same cycle.
  - Required: single MIG_RST restart, `drop_cnt`=2.
- Timeout/status collision:
  - Stimulus: synchronized `mig_ok` rises exactly on the 20th MIG_WAIT edge.
  - Required: → GT_RST, `retry_cnt` unchanged.
- Reset mid-operation:
  - Stimulus: `rst_sys` pulsed in GT_WAIT and again in FAIL.
  - Required: next edge all outputs at reset values, `seq_state`=0; sequence restarts from E0.
